// File: rtl/div_seq_if.sv
// Operand/result bundle for div_seq. The requester drives a, b and start.
// The divider drives done, div_zero, hi and lo.
interface div_seq_if;
    // Handshake: start acts as "valid". The divider is "ready" only in IDLE,
    // so start in any other state is ignored. a and b are sampled only on the
    // edge that accepts start. done (with div_zero on a zero divisor) pulses
    // for one cycle when the result is ready. hi and lo hold their values
    // until the next completion.
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output a, b, start, input done, div_zero, hi, lo);
    modport slave  (input a, b, start, output done, div_zero, hi, lo);
endinterface

// File: rtl/div_seq.sv
// Sequential signed 32/32 restoring divider: quotient in lo, remainder in hi.
// Optional macro DIV_ZERO_CHECK_EN short-circuits a zero divisor to a flagged done.
module div_seq (
    input  logic       clk,
    input  logic       reset,
    div_seq_if.slave   bus,
    output logic [1:0] fsm_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] b_mag;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] rem_next;
    logic [31:0] quo_next;

    // One restoring step: the 33-bit trial result's MSB marks a negative difference.
    always_comb begin
        shifted  = {rem, quo[31]};
        trial    = shifted - {1'b0, b_mag};
        rem_next = trial[32] ? shifted[31:0] : trial[31:0];
        quo_next = {quo[30:0], ~trial[32]};
    end

`ifdef DIV_ZERO_CHECK_EN
    logic dz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dz <= 1'b0;
        end else if (state == S_IDLE && bus.start) begin
            dz <= (bus.b == 32'd0);
        end else if (state == S_DONE) begin
            dz <= 1'b0;
        end
    end

    assign bus.div_zero = (state == S_DONE) && dz;
`else
    assign bus.div_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= 5'd0;
            rem    <= 32'd0;
            quo    <= 32'd0;
            b_mag  <= 32'd0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        sign_a <= bus.a[31];
                        sign_b <= bus.b[31];
                        quo    <= bus.a[31] ? -bus.a : bus.a;
                        b_mag  <= bus.b[31] ? -bus.b : bus.b;
                        rem    <= 32'd0;
                        cnt    <= 5'd0;
`ifdef DIV_ZERO_CHECK_EN
                        state  <= (bus.b == 32'd0) ? S_DONE : S_RUN;
`else
                        state  <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    lo_q  <= (sign_a ^ sign_b) ? -quo : quo;
                    hi_q  <= sign_a ? -rem : rem;
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.done = (state == S_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign fsm_state = state;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a vector table plus hand-written multi-cycle sequences.
// Expected results are hand-computed; DIV_ZERO_CHECK_EN selects the zero-divisor expectation.
module tb_div_seq;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] fsm_state;

    div_seq_if bus ();

    div_seq dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
    } vec_t;

    vec_t        vecs[11];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_item;
    logic [31:0] prev_hi = 32'd0;
    logic [31:0] prev_lo = 32'd0;
    int          n;
    int          done_seen;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Returns the index of the first negedge (counted from now) with done high, 0 on timeout.
    task automatic wait_done(input int budget, output int cnt);
        cnt = 0;
        for (int j = 1; j <= budget; j++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                cnt = j;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input int got_lat, input int exp_lat,
                                input logic exp_dz, input bit single_pulse);
        check32({name, "_latency"}, 32'(got_lat), 32'(exp_lat));
        exp_item = exp_q.pop_front();
        if (got_lat != 0) begin
            check32({name, "_hi"}, bus.hi, exp_item[63:32]);
            check32({name, "_lo"}, bus.lo, exp_item[31:0]);
            check32({name, "_div_zero"}, {31'd0, bus.div_zero}, {31'd0, exp_dz});
        end
        prev_hi = exp_item[63:32];
        prev_lo = exp_item[31:0];
        if (single_pulse) begin
            @(negedge clk);
            check32({name, "_done_one_cycle"}, {31'd0, bus.done}, 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{32'd100,       32'd7,         32'd14,        32'd2};
        vecs[1]  = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE};
        vecs[2]  = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2};
        vecs[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE};
        vecs[4]  = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
        vecs[5]  = '{32'h7FFFFFFF,  32'd1,         32'h7FFFFFFF,  32'd0};
        vecs[6]  = '{32'd0,         32'd5,         32'd0,         32'd0};
        vecs[7]  = '{32'd7,         32'd100,       32'd0,         32'd7};
        vecs[8]  = '{32'h80000000,  32'h80000000,  32'd1,         32'd0};
        vecs[9]  = '{32'h7FFFFFFF,  32'h80000000,  32'd0,         32'h7FFFFFFF};
        vecs[10] = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF};

        reset     = 1'b1;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset_done", {31'd0, bus.done}, 32'd0);
        check32("reset_div_zero", {31'd0, bus.div_zero}, 32'd0);
        check32("reset_hi", bus.hi, 32'd0);
        check32("reset_lo", bus.lo, 32'd0);
        check32("reset_state", {30'd0, fsm_state}, 32'd0);
        reset = 1'b0;

        // Table: done on the 34th negedge after the start edge; hi/lo hold mid-run.
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back({vecs[i].exp_hi, vecs[i].exp_lo});
            start_div(vecs[i].a, vecs[i].b);
            repeat (20) @(negedge clk);
            check32($sformatf("vec%0d_hold_hi", i), bus.hi, prev_hi);
            check32($sformatf("vec%0d_hold_lo", i), bus.lo, prev_lo);
            check32($sformatf("vec%0d_no_early_done", i), {31'd0, bus.done}, 32'd0);
            wait_done(40, n);
            check_result($sformatf("vec%0d", i), n, 14, 1'b0, 1'b1);
        end

        // Zero divisor, positive and negative dividend.
`ifdef DIV_ZERO_CHECK_EN
        exp_q.push_back({prev_hi, prev_lo});
        start_div(32'd5, 32'd0);
        wait_done(40, n);
        check_result("divzero_pos", n, 1, 1'b1, 1'b1);
        exp_q.push_back({prev_hi, prev_lo});
        start_div(32'hFFFFFFFB, 32'd0);
        wait_done(40, n);
        check_result("divzero_neg", n, 1, 1'b1, 1'b1);
`else
        exp_q.push_back({32'd5, 32'hFFFFFFFF});
        start_div(32'd5, 32'd0);
        wait_done(40, n);
        check_result("divzero_pos", n, 34, 1'b0, 1'b1);
        exp_q.push_back({32'hFFFFFFFB, 32'd1});
        start_div(32'hFFFFFFFB, 32'd0);
        wait_done(40, n);
        check_result("divzero_neg", n, 34, 1'b0, 1'b1);
`endif

        // Second start at edge N+10 with new operands is ignored.
        exp_q.push_back({32'd2, 32'd14});
        start_div(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(40, n);
        check_result("restart_ignored", n, 24, 1'b0, 1'b1);

        // start held through DONE launches a second division on the following IDLE edge.
        exp_q.push_back({32'd2, 32'd14});
        exp_q.push_back({32'hFFFFFFFE, 32'hFFFFFFF2});
        @(negedge clk);
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        wait_done(40, n);
        check_result("held_first", n, 34, 1'b0, 1'b0);
        bus.a = 32'hFFFFFF9C;
        wait_done(40, n);
        bus.start = 1'b0;
        check_result("held_second", n, 35, 1'b0, 1'b1);

        // Reset mid-run aborts the operation without a done pulse.
        start_div(32'd100, 32'd7);
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check32("abort_hi_async", bus.hi, 32'd0);
        check32("abort_lo_async", bus.lo, 32'd0);
        check32("abort_state_async", {30'd0, fsm_state}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        done_seen = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check32("abort_no_done", 32'(done_seen), 32'd0);
        check32("abort_hi_cleared", bus.hi, 32'd0);
        check32("abort_lo_cleared", bus.lo, 32'd0);

        exp_q.push_back({32'd2, 32'd14});
        start_div(32'd100, 32'd7);
        wait_done(40, n);
        check_result("after_abort", n, 34, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port a, input, 32 bits: signed dividend (two's complement), sampled only on the start edge.
REQ-004 The block SHALL have the port b, input, 32 bits: signed divisor, sampled only on the start edge.
REQ-005 The block SHALL have the port start, input, 1 bit: request a division; honoured only in IDLE.
REQ-006 The block SHALL have the port done, output, 1 bit: one-cycle pulse when hi/lo are updated, or when div_zero is raised.
REQ-007 The block SHALL have the port div_zero, output, 1 bit: one-cycle pulse, coincident with done, on a zero divisor.
REQ-008 The block SHALL have the port hi, output, 32 bits: remainder register.
REQ-009 The block SHALL have the port lo, output, 32 bits: quotient register.

Function
REQ-010 The block SHALL implement a Moore FSM with the states IDLE, RUN, FIX and DONE.
REQ-011 IDLE, with start=1 on edge N: a, b, sign(a) and sign(b) SHALL be latched, the magnitudes |a| and |b| formed, the 5-bit counter cleared, and the FSM SHALL go to RUN.
REQ-012 RUN SHALL perform one unsigned restoring step per edge, for exactly 32 edges (N+1..N+32):
  - shift {rem,quo} left by 1;
  - trial-subtract |b| from rem using 33-bit arithmetic;
  - if the result is non-negative, keep it and set quo[0]=1; otherwise keep rem and set quo[0]=0.
  After the 32nd step the FSM SHALL go to FIX.
REQ-013 FIX (edge N+33) SHALL apply sign correction and register the results:
  - lo = quo, negated if sign(a) differs from sign(b);
  - hi = rem, negated if sign(a)=1;
  - the FSM SHALL go to DONE.
REQ-014 DONE SHALL assert done for exactly one cycle (the cycle after edge N+33) and SHALL return to IDLE on the next edge.
REQ-015 The quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-016 For a=0x80000000, b=0xFFFFFFFF the block SHALL produce lo=0x80000000, hi=0x00000000, with no flag.
REQ-017 start asserted in RUN, FIX or DONE SHALL be ignored. start held high through DONE SHALL begin a new division on the IDLE edge that follows.
REQ-018 hi and lo SHALL hold their values between completions and SHALL change only in FIX.
REQ-019 Changes on a and b after the start edge SHALL NOT affect the result in progress.

Reset
REQ-020 While reset=1, the FSM SHALL be in IDLE and the outputs SHALL be done=0, div_zero=0, hi=0, lo=0, with the counter and internal registers cleared, independent of clk.
REQ-021 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow the deassertion of reset.

Configuration
REQ-022 With the macro DIV_ZERO_CHECK_EN defined, b=0 on the start edge SHALL cause:
  - the FSM goes IDLE→DONE directly;
  - done=1 and div_zero=1 in the next cycle;
  - hi and lo unchanged.
REQ-023 With DIV_ZERO_CHECK_EN undefined:
  - div_zero SHALL be tied to 0;
  - b=0 SHALL run the full 33-edge sequence;
  - the result SHALL be lo=0xFFFFFFFF if a>=0 else lo=0x00000001, and hi=a.

Verification
REQ-024 a=100, b=7, start pulse at edge N -> done high only in the cycle after N+33; lo=14, hi=2.
REQ-025 a=-100 (0xFFFFFF9C), b=7 -> lo=-14 (0xFFFFFFF2), hi=-2 (0xFFFFFFFE); a=100, b=-7 -> lo=-14, hi=2.
REQ-026 a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; div_zero=0.
REQ-027 a=5, b=0:
  - with DIV_ZERO_CHECK_EN: done=div_zero=1 one cycle after start, hi/lo unchanged;
  - without it: done at N+33 with lo=0xFFFFFFFF, hi=5.
REQ-028 Start a=100, b=7; pulse start again with new operands at edge N+10 -> second start ignored, result still lo=14, hi=2.
REQ-029 Start a division; assert reset at edge N+15 for 2 cycles; release -> hi=lo=0, no done pulse; a fresh start then completes normally.
